// File: rtl/io_irq_ctrl.sv
// io_irq_ctrl -- memory-mapped interrupt controller.
//
// Collects CIrqCnt raw interrupt sources into a Pending register. Each source
// is edge- or level-sensitive, selected by its Mode bit. The lowest-numbered
// pending and enabled source is offered to the core through a three-state
// handshake: IDLE -> REQ (AIrqO high) -> SERV (after ack) -> IDLE (after EOI).
//
// Register window (four 32-bit words at CAddrBase):
//   +0x0 IrqEn   RW   per-source enable
//   +0x4 Pending R/W1C latched requests
//   +0x8 Mode    RW   1 = edge, 0 = level
//   +0xC Status  RO   [31] AIrqO, [9:8] state, [4:0] FIdx
//
// Ports:
//   AClkH, AResetH, AClkHEn   clock, sync active-high reset, clock enable
//   AIoAddr, AIoMosi, AIoMiso I/O address, write data, read data (64-bit)
//   AIoWrSize, AIoRdSize      access size in bytes, 0 = no access
//   AIoAddrAck, AIoAddrErr    combinational decode status
//   AIrqI                     raw interrupt sources
//   AIrqO, AIrqIdx            request to core and index of requested source
//   AIrqAck, AIrqEoi          core accepts request / ends service
module io_irq_ctrl #(
  parameter logic [15:0] CAddrBase = 16'h0000,
  parameter int          CIrqCnt   = 16
) (
  input  logic               AClkH,
  input  logic               AResetH,
  input  logic               AClkHEn,
  input  logic [15:0]        AIoAddr,
  input  logic [63:0]        AIoMosi,
  output logic [63:0]        AIoMiso,
  input  logic [3:0]         AIoWrSize,
  input  logic [3:0]         AIoRdSize,
  output logic               AIoAddrAck,
  output logic               AIoAddrErr,
  input  logic [CIrqCnt-1:0] AIrqI,
  output logic               AIrqO,
  output logic [4:0]         AIrqIdx,
  input  logic               AIrqAck,
  input  logic               AIrqEoi
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  // Word select, i.e. address bits [3:2] within the window.
  localparam logic [1:0] SEL_EN   = 2'd0;
  localparam logic [1:0] SEL_PEND = 2'd1;
  localparam logic [1:0] SEL_MODE = 2'd2;
  localparam logic [1:0] SEL_STAT = 2'd3;

  state_t             state, state_next;
  logic [CIrqCnt-1:0] irq_en, pending, mode, irq_prev;
  logic [4:0]         fidx;

  // ---------------------------------------------------------------- decode
  logic               in_win, wr_req, rd_req, size_ok, wr_hit, rd_hit;
  logic [1:0]         sel;
  logic [CIrqCnt-1:0] wdata;

  assign in_win  = (AIoAddr[15:4] == CAddrBase[15:4]);
  assign wr_req  = (AIoWrSize != 4'd0);
  assign rd_req  = (AIoRdSize != 4'd0);
  assign size_ok = (!wr_req || AIoWrSize == 4'd4) && (!rd_req || AIoRdSize == 4'd4);
  assign sel     = AIoAddr[3:2];
  assign wdata   = AIoMosi[CIrqCnt-1:0];

  // All four word-aligned offsets in the window are registers, so only a
  // misaligned offset or a wrong size is a decode error.
  assign AIoAddrAck = in_win && (wr_req || rd_req) && size_ok && (AIoAddr[1:0] == 2'b00);
  assign AIoAddrErr = in_win && (wr_req || rd_req) && !AIoAddrAck;
  assign wr_hit     = AIoAddrAck && wr_req;
  assign rd_hit     = AIoAddrAck && rd_req;

  // ------------------------------------------------------ pending / priority
  logic [CIrqCnt-1:0] edge_set, w1c, ack_clr, pend_next, masked;
  logic [31:0]        masked32;
  logic [4:0]         win;
  logic               any_masked;

  assign edge_set = AIrqI & ~irq_prev & mode;
  assign w1c      = (wr_hit && sel == SEL_PEND) ? wdata : '0;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < CIrqCnt; i++)
      ack_clr[i] = (state == ST_REQ) && AIrqAck && (fidx == 5'(i));
  end

  // Edge bits: a new edge wins over any clear in the same cycle.
  // Level bits: follow the registered input, so clears do not stick.
  assign pend_next = (mode & (edge_set | (pending & ~(w1c | ack_clr))))
                   | (~mode & irq_prev);

  assign masked     = pending & irq_en;
  assign masked32   = 32'(masked);
  assign any_masked = |masked;

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    win = '0;
    for (int i = CIrqCnt - 1; i >= 0; i--)
      if (masked[i]) win = 5'(i);
  end

  // -------------------------------------------------------------- registers
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      irq_en   <= '0;
      mode     <= '0;
      pending  <= '0;
      irq_prev <= '0;
      fidx     <= '0;
    end else if (AClkHEn) begin
      irq_prev <= AIrqI;
      pending  <= pend_next;
      if (wr_hit && sel == SEL_EN)   irq_en <= wdata;
      if (wr_hit && sel == SEL_MODE) mode   <= wdata;
      // Index only moves in IDLE, so it is stable for the whole handshake.
      if (state == ST_IDLE && any_masked) fidx <= win;
    end
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge AClkH) begin
    if (AResetH)      state <= ST_IDLE;
    else if (AClkHEn) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (any_masked) state_next = ST_REQ;
      ST_REQ: begin
        // Ack wins over a simultaneous withdraw.
        if (AIrqAck)                state_next = ST_SERV;
        else if (!masked32[fidx])   state_next = ST_IDLE;
      end
      ST_SERV: if (AIrqEoi) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    AIrqO   = (state == ST_REQ);
    AIrqIdx = fidx;
  end

  // ------------------------------------------------------------- read mux
  logic [63:0] rdata;

  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      case (sel)
        SEL_EN:   rdata[31:0] = 32'(irq_en);
        SEL_PEND: rdata[31:0] = 32'(pending);
        SEL_MODE: rdata[31:0] = 32'(mode);
        SEL_STAT: rdata[31:0] = {AIrqO, 21'd0, state, 3'd0, fidx};
        default:  rdata       = '0;
      endcase
    end
  end

  assign AIoMiso = rdata;

endmodule

// File: doc/io_irq_ctrl.md
IO_IRQ_CTRL -- requirements
Module: io_irq_ctrl

Interface
REQ-001 SHALL have parameter CAddrBase, default 16'h0000, I/O window base (16-byte aligned).
REQ-002 SHALL have parameter CIrqCnt, default 16, number of IRQ inputs, legal 1..32.
REQ-003 SHALL have port AClkH, in, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port AResetH, in, 1, synchronous active-high reset.
REQ-005 SHALL have port AClkHEn, in, 1, clock enable; state updates only when 1, except reset.
REQ-006 SHALL have port AIoAddr, in, 16, I/O address.
REQ-007 SHALL have ports AIoMosi, in, 64, write data, and AIoMiso, out, 64, read data.
REQ-008 SHALL have ports AIoWrSize and AIoRdSize, in, 4 each, access size in bytes; 0 means no access.
REQ-009 SHALL have ports AIoAddrAck and AIoAddrErr, out, 1 each, combinational decode status.
REQ-010 SHALL have port AIrqI, in, CIrqCnt, raw IRQ sources.
REQ-011 SHALL have ports AIrqO, out, 1, request to core, and AIrqIdx, out, 5, index of requested source.
REQ-012 SHALL have ports AIrqAck, in, 1, core accepts request, and AIrqEoi, in, 1, core ends service.

Function
REQ-013 SHALL map registers at CAddrBase + 0x0 IrqEn (RW), +0x4 Pending (R, write-1-to-clear), +0x8 Mode (RW, 1 = edge, 0 = level), +0xC Status (RO).
REQ-014 SHALL assert AIoAddrAck when address hits a register offset and size = 4; SHALL assert AIoAddrErr for an in-window address with size not 4 or a non-register offset; neither outside the window or with size 0.
REQ-015 SHALL return read data combinationally in the same cycle, zero-extended to 64 bits; AIoMiso = 0 when no acknowledged read.
REQ-016 SHALL make written register values visible on the first cycle after the write edge; unused upper bits read 0 and ignore writes.
REQ-017 SHALL register AIrqI once into FIrqPrev; an edge-mode bit SHALL set Pending on AIrqI=1 and FIrqPrev=0.
REQ-018 SHALL, for a level-mode bit, load Pending from the registered input each cycle; W1C has no lasting effect on it.
REQ-019 SHALL, on simultaneous edge-set and clear (W1C or ack) of one bit, leave the bit set.
REQ-020 SHALL form Masked = Pending & IrqEn; lowest index has highest priority.
REQ-021 SHALL implement FSM IDLE, REQ, SERV; IDLE on reset.
REQ-022 SHALL, in IDLE with Masked != 0, latch the winning index into FIdx and go to REQ next cycle.
REQ-023 SHALL, in REQ, drive AIrqO = 1 and AIrqIdx = FIdx; AIrqO = 0 in IDLE and SERV; AIrqIdx = FIdx in all states.
REQ-024 SHALL, in REQ with AIrqAck = 1, go to SERV and clear Pending[FIdx] if edge mode.
REQ-025 SHALL, in REQ with Masked[FIdx] = 0 and no ack, withdraw to IDLE; ack has priority if both occur in one cycle.
REQ-026 SHALL, in SERV with AIrqEoi = 1, go to IDLE; ignore AIrqAck outside REQ and AIrqEoi outside SERV.
REQ-027 SHALL read Status as bit 31 = AIrqO, bits 9:8 = state (0 IDLE, 1 REQ, 2 SERV), bits 4:0 = FIdx.
REQ-028 SHALL let a new higher-priority source pre-empt only through IDLE; FIdx is stable while in REQ.

Reset
REQ-029 SHALL, with AResetH = 1 on an edge, clear IrqEn, Pending, Mode, FIrqPrev and FIdx, set state IDLE and drive AIrqO = 0, regardless of AClkHEn.
REQ-030 SHALL, on reset mid-REQ or mid-SERV, abandon the transaction without requiring ack or EOI.

Verification
REQ-031 Edge: Mode=0xFFFF, IrqEn=0x0004, pulse AIrqI[2] -> Pending=0x0004, AIrqO=1 and AIrqIdx=2 two cycles after the edge.
REQ-032 Priority: pending bits 5 and 9, both enabled -> AIrqIdx=5; ack+EOI -> next request AIrqIdx=9.
REQ-033 Level: Mode=0, AIrqI[0] held high, ack+EOI -> re-request with AIrqIdx=0; input low -> no request.
REQ-034 Collision: edge on bit 3 in the same cycle as W1C of 0x8 -> Pending bit 3 stays 1.
REQ-035 Withdraw: in REQ, write IrqEn=0 -> IDLE the next cycle, AIrqO=0, Status[9:8]=0.
REQ-036 Bus: read at +0x4 with size 2 -> AIoAddrErr=1, AIoMiso=0; reset in SERV -> all registers 0, IDLE.
